// File: rtl/mem_intv_delay_if.sv
// Val/rdy channels of the memory rate-shaping stage: core request in, memory request out,
// memory response in, core response out.
interface mem_intv_delay_if #(
  parameter int REQ_BITS  = 78,
  parameter int RESP_BITS = 78
);
  logic                 req_in_val;
  logic                 req_in_rdy;
  logic [REQ_BITS-1:0]  req_in_msg;
  logic                 req_out_val;
  logic                 req_out_rdy;
  logic [REQ_BITS-1:0]  req_out_msg;
  logic                 resp_in_val;
  logic                 resp_in_rdy;
  logic [RESP_BITS-1:0] resp_in_msg;
  logic                 resp_out_val;
  logic                 resp_out_rdy;
  logic [RESP_BITS-1:0] resp_out_msg;

  // harness side: drives core requests, memory readiness and memory responses
  modport master (
    output req_in_val, req_in_msg, input req_in_rdy,
    input  req_out_val, req_out_msg, output req_out_rdy,
    output resp_in_val, resp_in_msg, input resp_in_rdy,
    input  resp_out_val, resp_out_msg, output resp_out_rdy
  );

  modport slave (
    input  req_in_val, req_in_msg, output req_in_rdy,
    output req_out_val, req_out_msg, input req_out_rdy,
    input  resp_in_val, resp_in_msg, output resp_in_rdy,
    output resp_out_val, resp_out_msg, input resp_out_rdy
  );
endinterface

// File: rtl/mem_intv_delay.sv
// Rate-shaping stage between core and test memory: spaces request and response handshakes,
// buffers responses in a small FIFO and caps in-flight transactions.
module mem_intv_delay #(
  parameter int p_req_bits        = 78,
  parameter int p_resp_bits       = 78,
  parameter int p_send_intv_delay = 1,
  parameter int p_recv_intv_delay = 1,
  parameter int p_resp_depth      = 2,
  parameter int p_max_outstanding = 4,
  localparam int OW  = $clog2(p_max_outstanding + 1),
  localparam int SCW = (p_send_intv_delay > 1) ? $clog2(p_send_intv_delay) : 1,
  localparam int RCW = (p_recv_intv_delay > 1) ? $clog2(p_recv_intv_delay) : 1,
  localparam int PW  = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1,
  localparam int CW  = $clog2(p_resp_depth + 1)
) (
  input  logic              clk,
  input  logic              rst,
  mem_intv_delay_if.slave   bus,
  output logic [OW-1:0]     outstanding
);

  if (p_send_intv_delay < 1) begin : g_bad_send
    $error("p_send_intv_delay must be >= 1");
  end
  if (p_recv_intv_delay < 1) begin : g_bad_recv
    $error("p_recv_intv_delay must be >= 1");
  end
  if (p_resp_depth < 1) begin : g_bad_depth
    $error("p_resp_depth must be >= 1");
  end
  if (p_max_outstanding < 1) begin : g_bad_max
    $error("p_max_outstanding must be >= 1");
  end

  logic [SCW-1:0]         send_cnt;
  logic [RCW-1:0]         recv_cnt;
  logic [p_resp_bits-1:0] mem [p_resp_depth];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   send_ok, req_fire, enq, deq, full, empty;

  // send path is pure combinational gating of the core's handshake
  assign send_ok          = (send_cnt == '0) && (outstanding < OW'(p_max_outstanding));
  assign bus.req_out_val  = bus.req_in_val && send_ok;
  assign bus.req_in_rdy   = bus.req_out_rdy && send_ok;
  assign bus.req_out_msg  = bus.req_in_msg;
  assign req_fire         = bus.req_in_val && bus.req_out_rdy && send_ok;

  // full is registered-only, so a dequeue never frees a slot for a same-cycle enqueue
  assign full             = (count == CW'(p_resp_depth));
  assign empty            = (count == '0);
  assign bus.resp_in_rdy  = !full;
  assign enq              = bus.resp_in_val && !full;
  assign bus.resp_out_val = !empty && (recv_cnt == '0);
  assign bus.resp_out_msg = mem[rd_ptr];
  assign deq              = bus.resp_out_val && bus.resp_out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      if (req_fire)              send_cnt <= SCW'(p_send_intv_delay - 1);
      else if (send_cnt != '0)   send_cnt <= send_cnt - SCW'(1);
      if (deq)                   recv_cnt <= RCW'(p_recv_intv_delay - 1);
      else if (recv_cnt != '0)   recv_cnt <= recv_cnt - RCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PW'(p_resp_depth - 1)) ? '0 : wr_ptr + PW'(1);
      if (deq) rd_ptr <= (rd_ptr == PW'(p_resp_depth - 1)) ? '0 : rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= bus.resp_in_msg;
  end

  // underflow would mean memory answered a request that was never sent; hold at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, deq})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - OW'(1);
        default: ;
      endcase
    end
  end

  resp_underflow: assert property (@(posedge clk) disable iff (rst)
    (deq && !req_fire) |-> (outstanding != '0));

endmodule

// File: tb/tb_mem_intv_delay.sv
// Bench for mem_intv_delay: instance A (spacing 3/3, depth 2, cap 4) and
// instance B (spacing 1/1, depth 3, cap 2), responses checked through scoreboards.
module tb_mem_intv_delay;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_intv_delay_if #(.REQ_BITS(78), .RESP_BITS(78)) ifa ();
  mem_intv_delay_if #(.REQ_BITS(78), .RESP_BITS(78)) ifb ();
  logic [2:0] out_a;
  logic [1:0] out_b;

  mem_intv_delay #(.p_req_bits(78), .p_resp_bits(78), .p_send_intv_delay(3),
    .p_recv_intv_delay(3), .p_resp_depth(2), .p_max_outstanding(4))
  dut_a (.clk(clk), .rst(rst), .bus(ifa), .outstanding(out_a));

  mem_intv_delay #(.p_req_bits(78), .p_resp_bits(78), .p_send_intv_delay(1),
    .p_recv_intv_delay(1), .p_resp_depth(3), .p_max_outstanding(2))
  dut_b (.clk(clk), .rst(rst), .bus(ifb), .outstanding(out_b));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [77:0] exp_a[$];
  logic [77:0] exp_b[$];
  int a_out_cyc[$];
  int a_last = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [77:0] mk(input int i);
    return {14'(i), 32'hC0DE_F00D, 32'(i * 7 + 1)};
  endfunction

  // response scoreboards; A also checks minimum spacing of 3 between deliveries
  always @(negedge clk) begin
    if (rst) a_last = -100;
    else if (ifa.resp_out_val && ifa.resp_out_rdy) begin
      if (exp_a.size() == 0) chk("a_resp_unexpected", ifa.resp_out_val, 1'b0);
      else chk("a_resp_msg", ifa.resp_out_msg, exp_a.pop_front());
      chk("a_resp_gap_min", 1'((cyc - a_last) >= 3), 1'b1);
      a_last = cyc;
      a_out_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.resp_out_val && ifb.resp_out_rdy) begin
      if (exp_b.size() == 0) chk("b_resp_unexpected", ifb.resp_out_val, 1'b0);
      else chk("b_resp_msg", ifb.resp_out_msg, exp_b.pop_front());
    end
  end

  task automatic b_req(input logic [77:0] m);
    bit ok = 0;
    ifb.req_in_val = 1'b1;
    ifb.req_in_msg = m;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      ok = ifb.req_in_rdy;
      if (ok) chk("b_req_msg", ifb.req_out_msg, m);
      tick();
    end
    ifb.req_in_val = 1'b0;
    if (!ok) chk("b_req_timeout", ifb.req_in_rdy, 1'b1);
  endtask

  task automatic b_resp(input logic [77:0] m);
    bit ok = 0;
    ifb.resp_in_val = 1'b1;
    ifb.resp_in_msg = m;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      ok = ifb.resp_in_rdy;
      if (ok) exp_b.push_back(m);
      tick();
    end
    ifb.resp_in_val = 1'b0;
    if (!ok) chk("b_resp_timeout", ifb.resp_in_rdy, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [77:0] a_msg;
    int n;
    {ifa.req_in_val, ifa.req_out_rdy, ifa.resp_in_val, ifa.resp_out_rdy} = '0;
    {ifb.req_in_val, ifb.req_out_rdy, ifb.resp_in_val, ifb.resp_out_rdy} = '0;
    ifa.req_in_msg = '0; ifa.resp_in_msg = '0;
    ifb.req_in_msg = '0; ifb.resp_in_msg = '0;

    // reset held for two edges with a request pending
    rst = 1'b1;
    a_msg = mk(1);
    ifa.req_in_val = 1'b1; ifa.req_out_rdy = 1'b1; ifa.req_in_msg = a_msg;
    @(negedge clk);
    chk("a_rst_resp_out_val", ifa.resp_out_val, 1'b0);
    chk("a_rst_resp_in_rdy", ifa.resp_in_rdy, 1'b1);
    chk("a_rst_outstanding", out_a, 0);
    chk("b_rst_resp_in_rdy", ifb.resp_in_rdy, 1'b1);
    chk("b_rst_outstanding", out_b, 0);
    tick();
    rst = 1'b0;

    // send spacing 3: handshakes at cycles 0,3,6,9 only
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("a_send_rdy_c%0d", c), ifa.req_in_rdy, 1'((c % 3) == 0));
      if (c == 0) chk("a_rst_pass_val", ifa.req_out_val, 1'b1);
      if ((c % 3) == 0) chk($sformatf("a_send_msg_c%0d", c), ifa.req_out_msg, a_msg);
      tick();
      if ((c % 3) == 0) begin a_msg = mk(c + 2); ifa.req_in_msg = a_msg; end
    end
    ifa.req_in_val = 1'b0;
    @(negedge clk);
    chk("a_send_outstanding", out_a, 4);
    tick();

    // receive spacing and FIFO back-pressure: consumer stalls 4 cycles first
    fork
      begin : prod
        bit ok;
        logic [77:0] pm;
        for (int i = 0; i < 4; i++) begin
          pm = mk(100 + i);
          ok = 0;
          ifa.resp_in_val = 1'b1; ifa.resp_in_msg = pm;
          for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge clk);
            if (i == 2 && w == 0) chk("a_fifo_full_rdy", ifa.resp_in_rdy, 1'b0);
            if (ifa.resp_in_rdy) begin ok = 1; exp_a.push_back(pm); end
            tick();
          end
          if (!ok) chk("a_resp_in_timeout", ifa.resp_in_rdy, 1'b1);
        end
        ifa.resp_in_val = 1'b0;
      end
      begin : cons
        repeat (4) tick();
        ifa.resp_out_rdy = 1'b1;
      end
    join
    for (int w = 0; w < 40 && exp_a.size() > 0; w++) tick();
    chk("a_drain", exp_a.size(), 0);
    chk("a_out_count", a_out_cyc.size(), 4);
    for (int k = 1; k < a_out_cyc.size(); k++)
      chk($sformatf("a_resp_gap%0d", k), a_out_cyc[k] - a_out_cyc[k-1], 3);
    chk("a_recv_outstanding", out_a, 0);

    // outstanding cap of 2 on B
    ifb.req_out_rdy = 1'b1; ifb.resp_out_rdy = 1'b1;
    ifb.req_in_val = 1'b1; ifb.req_in_msg = mk(200);
    @(negedge clk); chk("b_cap_rdy0", ifb.req_in_rdy, 1'b1); tick();
    @(negedge clk); chk("b_cap_rdy1", ifb.req_in_rdy, 1'b1); tick();
    @(negedge clk);
    chk("b_cap_block", ifb.req_in_rdy, 1'b0);
    chk("b_cap_outstanding", out_b, 2);
    tick();
    ifb.resp_in_val = 1'b1; ifb.resp_in_msg = mk(201);
    @(negedge clk);
    chk("b_r1_enq", ifb.resp_in_rdy, 1'b1); exp_b.push_back(mk(201));
    chk("b_cap_block2", ifb.req_in_rdy, 1'b0);
    tick();
    ifb.resp_in_val = 1'b0;
    @(negedge clk);
    chk("b_r1_visible", ifb.resp_out_val, 1'b1);
    chk("b_cap_block3", ifb.req_in_rdy, 1'b0);
    tick();
    @(negedge clk); chk("b_cap_reopen", ifb.req_in_rdy, 1'b1); tick();
    ifb.req_in_val = 1'b0;
    @(negedge clk); chk("b_cap_after", out_b, 2); tick();

    // one response with no request: count drops to 1
    ifb.resp_in_val = 1'b1; ifb.resp_in_msg = mk(202);
    @(negedge clk); chk("b_r2_enq", ifb.resp_in_rdy, 1'b1); exp_b.push_back(mk(202)); tick();
    ifb.resp_in_val = 1'b0;
    @(negedge clk); chk("b_r2_visible", ifb.resp_out_val, 1'b1); tick();
    @(negedge clk); chk("b_r2_outstanding", out_b, 1); tick();

    // request and response-out handshake in the same cycle
    ifb.resp_in_val = 1'b1; ifb.resp_in_msg = mk(203);
    @(negedge clk); chk("b_r3_enq", ifb.resp_in_rdy, 1'b1); exp_b.push_back(mk(203)); tick();
    ifb.resp_in_val = 1'b0; ifb.req_in_val = 1'b1; ifb.req_in_msg = mk(204);
    @(negedge clk);
    chk("b_sim_req_rdy", ifb.req_in_rdy, 1'b1);
    chk("b_sim_resp_val", ifb.resp_out_val, 1'b1);
    tick();
    ifb.req_in_val = 1'b0;
    @(negedge clk); chk("b_sim_outstanding", out_b, 1); tick();

    // seven more entries through the depth-3 FIFO to exercise pointer wrap
    for (int i = 0; i < 7; i++) begin
      b_req(mk(400 + i));
      b_resp(mk(500 + i));
    end
    for (int w = 0; w < 40 && exp_b.size() > 0; w++) tick();
    chk("b_drain", exp_b.size(), 0);
    chk("b_wrap_outstanding", out_b, 1);

    // mid-cycle reset with two buffered responses and three in flight on A
    ifa.resp_out_rdy = 1'b0;
    ifa.req_in_val = 1'b1; ifa.req_in_msg = mk(300);
    n = 0;
    for (int w = 0; w < 30 && n < 3; w++) begin
      @(negedge clk);
      if (ifa.req_in_rdy) n++;
      tick();
    end
    ifa.req_in_val = 1'b0;
    chk("a_mr_reqs", n, 3);
    ifa.resp_in_val = 1'b1; ifa.resp_in_msg = mk(301);
    @(negedge clk); chk("a_mr_enq0", ifa.resp_in_rdy, 1'b1); exp_a.push_back(mk(301)); tick();
    ifa.resp_in_msg = mk(302);
    @(negedge clk); chk("a_mr_enq1", ifa.resp_in_rdy, 1'b1); exp_a.push_back(mk(302)); tick();
    ifa.resp_in_val = 1'b0;
    @(negedge clk);
    chk("a_mr_pre_val", ifa.resp_out_val, 1'b1);
    chk("a_mr_pre_full", ifa.resp_in_rdy, 1'b0);
    chk("a_mr_pre_out", out_a, 3);
    #1 rst = 1'b1;
    #1;
    chk("a_mr_val", ifa.resp_out_val, 1'b0);
    chk("a_mr_out", out_a, 0);
    chk("a_mr_rdy", ifa.resp_in_rdy, 1'b1);
    exp_a.delete();
    #1 rst = 1'b0;
    ifa.resp_out_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("a_mr_stale%0d", k), ifa.resp_out_val, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
